// File: rtl/wb_slave_regfile_pkg.sv
// Package for wb_slave_regfile: FSM state encoding and bus geometry helpers.
// No ports. Imported by wb_slave_regfile and wb_slave_regfile_mem.
package wb_slave_regfile_pkg;

  // Transfer FSM: capture request, count wait states, one-cycle response.
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_WAIT = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

  // Number of byte lanes on a data bus of the given width.
  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Index width for a table of n entries, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_slave_regfile_mem.sv
// Register array with a byte-enable synchronous write port and an
// asynchronous read port. All entries clear on synchronous reset.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, clears every entry
//   we_i       write strobe for this cycle
//   waddr_i    write index
//   wdata_i    write data
//   wsel_i     byte lane enables for the write
//   raddr_i    read index
//   rdata_c_o  read data, combinational from raddr_i
module wb_slave_regfile_mem
  import wb_slave_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_W      = idx_width(NUM_REGS),
  parameter int unsigned LANES      = lane_count(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [LANES-1:0]      wsel_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_c_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // Byte-lane merge: unselected lanes keep their contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wsel_i[b]) begin
          regs_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_c_o = regs_q[raddr_i];

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic slave exposing NUM_REGS read/write registers with a
// programmable number of wait states between request capture and ACK.
// Optional feature macro: WB_SLAVE_REGFILE_ERR_EN -- when defined, accesses to
// word addresses >= NUM_REGS terminate with err_o instead of ack_o.
// Ports:
//   clk_i  clock (posedge)          rst_i  synchronous active-high reset
//   cyc_i  bus cycle valid          stb_i  transfer strobe
//   we_i   1 = write, 0 = read      adr_i  word address
//   dat_i  write data               sel_i  byte lane enables
//   dat_o  read data, nonzero only while ack_o is high
//   ack_o  normal termination       err_o  error termination
module wb_slave_regfile
  import wb_slave_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int unsigned LANES = lane_count(DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(NUM_REGS);
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [LANES-1:0]      sel_q, sel_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

  logic                  in_range_c;
  logic                  err_term_c;
  logic                  mem_we_c;
  logic [DATA_WIDTH-1:0] mem_rdata_c;

  // Decode of the latched address against the implemented register count.
  assign in_range_c = (32'(adr_q) < NUM_REGS);

`ifdef WB_SLAVE_REGFILE_ERR_EN
  assign err_term_c = ~in_range_c;
`else
  assign err_term_c = 1'b0;
`endif

  wb_slave_regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .LANES      (LANES)
  ) u_mem (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (mem_we_c),
    .waddr_i   (IDX_W'(adr_q)),
    .wdata_i   (wdat_q),
    .wsel_i    (sel_q),
    .raddr_i   (IDX_W'(adr_q)),
    .rdata_c_o (mem_rdata_c)
  );

  // Next-state and response generation; outputs are set on entry to RESP so
  // that ack_o/err_o/dat_o are flop outputs during the response cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    mem_we_c = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d   = adr_i;
          we_d    = we_i;
          wdat_d  = dat_i;
          sel_d   = sel_i;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = STATE_WAIT;
        end
      end
      STATE_WAIT: begin
        // Master abort wins over expiry; a low strobe stalls the countdown.
        if (!cyc_i) begin
          state_d = STATE_IDLE;
        end else if (stb_i) begin
          if (cnt_q == '0) begin
            state_d = STATE_RESP;
            ack_d   = ~err_term_c;
            err_d   = err_term_c;
            if (!we_q && in_range_c) begin
              rdat_d = mem_rdata_c;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      STATE_RESP: begin
        // Out-of-range writes are discarded in every configuration.
        mem_we_c = we_q & in_range_c;
        state_d  = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= STATE_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = rdat_q;

endmodule
